// File: rtl/wide_param_pattern_gen_if.sv
// Stream interface for wide_param_pattern_gen: valid/ready word channel plus framing flags.
// The generator drives through the master modport; the sink uses the slave modport.
interface wide_param_pattern_gen_if #(
  parameter int CHUNK_W = 32,
  parameter int IDX_W   = 4
);
  logic               out_valid;
  logic               out_ready;
  logic [CHUNK_W-1:0] out_data;
  logic               out_first;
  logic               out_last;
  logic [IDX_W-1:0]   chunk_idx;

  modport master (
    output out_valid, out_data, out_first, out_last, chunk_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_first, out_last, chunk_idx,
    output out_ready
  );
endinterface

// File: rtl/wide_param_pattern_gen.sv
// Streams a wide parameter pattern as CHUNK_W words, LSB chunk first, for repeat_cnt+1 passes.
// Optional macro WIDE_PATGEN_PARITY_EN adds out_parity and run_parity outputs.
module wide_param_pattern_gen #(
  parameter int                   PATTERN_W = 256,
  parameter int                   CHUNK_W   = 32,
  parameter logic [PATTERN_W-1:0] PATTERN   = '0,
  parameter int                   REPEAT_W  = 8,
  parameter int                   MODE      = 0,
  localparam int                  NUM_CHUNKS = PATTERN_W / CHUNK_W,
  localparam int                  IDX_W      = $clog2(NUM_CHUNKS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [REPEAT_W-1:0]   repeat_cnt,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
`ifdef WIDE_PATGEN_PARITY_EN
  output logic                  out_parity,
  output logic                  run_parity,
`endif
  wide_param_pattern_gen_if.master stream
);

  if ((CHUNK_W < 1) || (CHUNK_W > PATTERN_W) || (PATTERN_W % CHUNK_W != 0)) begin : g_bad_width
    $error("wide_param_pattern_gen: PATTERN_W must be a nonzero multiple of CHUNK_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_e                state_q, state_d;
  logic [PATTERN_W-1:0]  pass_q, pass_d;
  logic [PATTERN_W-1:0]  shift_q, shift_d;
  logic [REPEAT_W-1:0]   passes_left_q, passes_left_d;
  logic [IDX_W-1:0]      chunk_idx_q, chunk_idx_d;
  logic                  handshake;
`ifdef WIDE_PATGEN_PARITY_EN
  logic                  out_parity_q, out_parity_d;
  logic                  run_parity_q, run_parity_d;
`endif

  // Pattern applied between passes; MODE is elaboration-time so only one arm survives.
  function automatic logic [PATTERN_W-1:0] next_pass(input logic [PATTERN_W-1:0] p);
    if (MODE == 1) begin
      return (p << 1) | (p >> (PATTERN_W - 1));
    end else if (MODE == 2) begin
      return ~p;
    end
    return p;
  endfunction

  assign handshake = (state_q == ST_STREAM) && stream.out_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    pass_d        = pass_q;
    shift_d       = shift_q;
    passes_left_d = passes_left_q;
    chunk_idx_d   = chunk_idx_q;
`ifdef WIDE_PATGEN_PARITY_EN
    run_parity_d  = run_parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          pass_d        = PATTERN;
          shift_d       = PATTERN;
          passes_left_d = repeat_cnt;
          chunk_idx_d   = '0;
          state_d       = ST_STREAM;
`ifdef WIDE_PATGEN_PARITY_EN
          run_parity_d  = 1'b0;
`endif
        end
      end
      ST_STREAM: begin
        if (handshake) begin
`ifdef WIDE_PATGEN_PARITY_EN
          run_parity_d = run_parity_q ^ (^shift_q[CHUNK_W-1:0]);
`endif
          if (chunk_idx_q != LAST_IDX) begin
            shift_d     = shift_q >> CHUNK_W;
            chunk_idx_d = chunk_idx_q + IDX_W'(1);
          end else if (passes_left_q != '0) begin
            // Back-to-back pass reload keeps out_valid high with no bubble.
            pass_d        = next_pass(pass_q);
            shift_d       = next_pass(pass_q);
            passes_left_d = passes_left_q - REPEAT_W'(1);
            chunk_idx_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
`ifdef WIDE_PATGEN_PARITY_EN
    out_parity_d = ^shift_d[CHUNK_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pass_q        <= '0;
      shift_q       <= '0;
      passes_left_q <= '0;
      chunk_idx_q   <= '0;
`ifdef WIDE_PATGEN_PARITY_EN
      out_parity_q  <= 1'b0;
      run_parity_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pass_q        <= pass_d;
      shift_q       <= shift_d;
      passes_left_q <= passes_left_d;
      chunk_idx_q   <= chunk_idx_d;
`ifdef WIDE_PATGEN_PARITY_EN
      out_parity_q  <= out_parity_d;
      run_parity_q  <= run_parity_d;
`endif
    end
  end

  assign busy             = (state_q == ST_STREAM);
  assign done             = (state_q == ST_DONE);
  assign stream.out_valid = busy;
  assign stream.out_data  = shift_q[CHUNK_W-1:0];
  assign stream.chunk_idx = chunk_idx_q;
  assign stream.out_first = busy && (chunk_idx_q == '0);
  assign stream.out_last  = busy && (chunk_idx_q == LAST_IDX) && (passes_left_q == '0);
`ifdef WIDE_PATGEN_PARITY_EN
  assign out_parity = out_parity_q;
  assign run_parity = done && run_parity_q;
`endif

endmodule

// File: doc/wide_param_pattern_gen.md
Name: wide_param_pattern_gen

Overview:
- Streams a wide, compile-time parameter pattern (up to hundreds of bits) out as a sequence of CHUNK_W-bit words on a valid/ready interface.
- Repeats the pattern for a programmable number of passes. A MODE parameter can transform the pattern between passes.
- Used as a parameter-driven stimulus/constant source in front of datapath blocks. It exercises wide logic parameters, including values above 32 bits and '1 fills, through real sequential logic.

Parameters:
- PATTERN_W, 256, width of the pattern in bits; must be a nonzero multiple of CHUNK_W.
- PATTERN, logic [PATTERN_W-1:0] = '0, the pattern to stream; no other default is permitted.
- CHUNK_W, 32, output word width; 1..PATTERN_W.
- REPEAT_W, 8, width of the repeat_cnt input.
- MODE, 0, inter-pass transform: 0 = repeat unchanged; 1 = rotate pattern left by 1 bit per pass; 2 = bitwise invert per pass.
- Derived localparam NUM_CHUNKS = PATTERN_W/CHUNK_W.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- repeat_cnt  in  REPEAT_W  number of passes minus one; sampled with start.
- abort  in  1  terminates any run; returns to IDLE.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse after the final chunk is accepted.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word.
- out_data  out  CHUNK_W  current chunk.
- out_first  out  1  chunk index 0 of any pass.
- out_last  out  1  final chunk of the final pass.
- chunk_idx  out  $clog2(NUM_CHUNKS)+1  index of the current chunk within the pass.

Behaviour:
- Reset, while rst_n=0 at a clk edge: state=IDLE. busy, done, out_valid, out_first and out_last are 0. out_data=0 and chunk_idx=0. Internal pass, shift and pass-counter registers are cleared.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - On start=1 and abort=0: pass_reg<=PATTERN, shift_reg<=PATTERN, passes_left<=repeat_cnt, chunk_idx<=0, then go to STREAM.
  - In the next cycle busy=1 and out_valid=1. Latency from start to first valid is 1 cycle.
- STREAM:
  - out_data=shift_reg[CHUNK_W-1:0]. Chunks go out LSB chunk first.
  - out_valid stays high, and out_data, out_first, out_last and chunk_idx stay stable, until out_valid&&out_ready.
  - On a handshake with chunk_idx<NUM_CHUNKS-1: shift_reg>>=CHUNK_W and chunk_idx++.
  - On a handshake with chunk_idx==NUM_CHUNKS-1 and passes_left>0:
    - compute next pass = T(pass_reg);
    - pass_reg<=next and shift_reg<=next;
    - passes_left-- and chunk_idx<=0.
    - There is no bubble: out_valid stays 1.
  - T depends on MODE: 0 → identity; 1 → {p[PATTERN_W-2:0],p[PATTERN_W-1]}; 2 → ~p.
  - On a handshake with chunk_idx==NUM_CHUNKS-1 and passes_left==0: out_valid<=0, busy<=0, go to DONE.
  - out_last = (chunk_idx==NUM_CHUNKS-1)&&(passes_left==0).
  - If NUM_CHUNKS==1, out_first and out_last may both be 1.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE unconditionally. A start seen in DONE is ignored.
- abort: in any state, the next state is IDLE with out_valid=0 and busy=0. No done pulse is issued.
- abort and start in the same cycle: abort wins.
- start while busy is ignored, and repeat_cnt is not resampled.
- Total handshakes per run = NUM_CHUNKS*(repeat_cnt+1). With repeat_cnt at its maximum, 2^REPEAT_W passes are produced; the counter does not wrap early.
- A rst_n=0 during STREAM takes effect at that edge with full reset values. A partially shifted pattern is discarded.
- Elaboration: PATTERN_W%CHUNK_W!=0 must produce an elaboration-time error ($error in a generate check).

Optional Feature:
- Macro WIDE_PATGEN_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = ^out_data, registered alongside out_data. It is valid under out_valid and has a reset value of 0.
  - Adds an internal running parity over all chunks accepted in a run. It is exposed as run_parity (1 bit), valid in the cycle done=1 and otherwise 0.
- Undefined: neither port exists and there is no parity logic. All other behaviour is identical.

Test Plan:
- Setup for all scenarios: PATTERN_W=256, CHUNK_W=32, MODE=0, out_ready tied to 1.
- PATTERN=4294967296, start with repeat_cnt=0:
  - chunk0=32'h0, chunk1=32'h1, chunks 2-7=0;
  - out_first on chunk0, out_last on chunk7;
  - done is asserted 1 cycle after chunk7;
  - exactly 8 handshakes.
- PATTERN='1, MODE=2, repeat_cnt=1:
  - 8×32'hFFFFFFFF, then 8×32'h0 with no bubble;
  - out_last only on the 16th word.
- PATTERN=429496729600 (64'h64_0000_0000), MODE=1, repeat_cnt=1:
  - pass0 chunk1=32'h64;
  - pass1 chunk1=32'hC8, with chunk0 of pass1 = 0.
- Backpressure: out_ready random 50% with PATTERN=1 → out_data/chunk_idx stay stable while valid&&!ready; the sequence equals the ready=1 case.
- abort at the 3rd valid cycle, then a new start with repeat_cnt=0:
  - out_valid=0 the cycle after abort, with no done pulse;
  - the new run starts from chunk0 and streams the full 8 chunks.
- rst_n=0 mid-stream and start asserted while busy:
  - reset gives all outputs 0 next cycle;
  - the mid-run start is ignored, so the handshake count is unchanged;
  - with WIDE_PATGEN_PARITY_EN, PATTERN=1 gives out_parity=1 on chunk0 and run_parity=1 at done.
